// File: rtl/mem_stage.sv
// Memory-access stage: non-memory ops pass straight through, loads/stores run
// one req/ack bus transaction with pipeline stall, lane extraction and timeout.
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [REG_AW-1:0] ex_wd,
  input  logic              ex_wreg,
  input  logic [3:0]        ex_memop,
  input  logic [31:0]       ex_mem_addr,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [31:0]       dbus_addr,
  output logic [3:0]        dbus_be,
  output logic [DATA_W-1:0] dbus_wdata,
  input  logic              dbus_ack,
  input  logic [DATA_W-1:0] dbus_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [REG_AW-1:0] mem_wd,
  output logic              mem_wreg,
  output logic              stall_req,
  output logic              misalign,
  output logic              bus_err
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [7:0]        r_cnt;
  logic [3:0]        r_op;
  logic [1:0]        r_lane;
  logic              r_abort;
  logic [DATA_W-1:0] r_rdata;
  logic              r_req, r_we, r_bus_err;
  logic [31:0]       r_addr;
  logic [3:0]        r_be;
  logic [DATA_W-1:0] r_wdata;

  logic              w_is_ld, w_is_st, w_mem, w_aligned, w_r_ld, w_limit;
  logic [1:0]        w_size;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata, w_ext;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  // Decode the EX/MEM request: size, alignment, byte enables, replicated data
  always_comb begin
    w_is_ld   = 1'b0;
    w_is_st   = 1'b0;
    w_size    = 2'd0;
    w_aligned = 1'b1;
    w_be      = 4'b0000;
    w_wdata   = '0;
    case (ex_memop)
      OP_LB, OP_LBU: begin w_is_ld = 1'b1; w_size = 2'd0; end
      OP_LH, OP_LHU: begin w_is_ld = 1'b1; w_size = 2'd1; end
      OP_LW:         begin w_is_ld = 1'b1; w_size = 2'd2; end
      OP_SB:         begin w_is_st = 1'b1; w_size = 2'd0; end
      OP_SH:         begin w_is_st = 1'b1; w_size = 2'd1; end
      OP_SW:         begin w_is_st = 1'b1; w_size = 2'd2; end
      default:       ;
    endcase
    case (w_size)
      2'd0: begin
        w_be    = 4'b0001 << ex_mem_addr[1:0];
        w_wdata = {4{ex_store_data[7:0]}};
      end
      2'd1: begin
        w_aligned = ~ex_mem_addr[0];
        w_be      = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{ex_store_data[15:0]}};
      end
      default: begin
        w_aligned = (ex_mem_addr[1:0] == 2'b00);
        w_be      = 4'b1111;
        w_wdata   = ex_store_data;
      end
    endcase
    if (!w_is_st) w_wdata = '0;
    w_mem = w_is_ld | w_is_st;
  end

  assign w_limit = (r_cnt == LP_CNT_LAST);
  assign w_r_ld  = (r_op >= OP_LB) && (r_op <= OP_LW);
  assign w_byte  = dbus_rdata[{r_lane, 3'b000} +: 8];
  assign w_half  = r_lane[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];

  always_comb begin
    case (r_op)
      OP_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_ext = {24'd0, w_byte};
      OP_LH:   w_ext = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_ext = {16'd0, w_half};
      default: w_ext = dbus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_mem && w_aligned) w_next = S_WAIT;
      S_WAIT:  if (dbus_ack || w_limit) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Bus fields stay frozen from request until the next transaction starts
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_op      <= '0;
      r_lane    <= '0;
      r_abort   <= 1'b0;
      r_rdata   <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mem && w_aligned) begin
            r_req   <= 1'b1;
            r_we    <= w_is_st;
            r_addr  <= {ex_mem_addr[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_op    <= ex_memop;
            r_lane  <= ex_mem_addr[1:0];
            r_cnt   <= '0;
            r_abort <= 1'b0;
          end
        end
        S_WAIT: begin
          if (dbus_ack) begin
            r_req   <= 1'b0;
            r_rdata <= w_ext;
          end else if (w_limit) begin
            r_req     <= 1'b0;
            r_bus_err <= 1'b1;
            r_abort   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign dbus_req   = r_req;
  assign dbus_we    = r_we;
  assign dbus_addr  = r_addr;
  assign dbus_be    = r_be;
  assign dbus_wdata = r_wdata;
  assign bus_err    = r_bus_err;

  // mem_wreg must never be high while stalled: MEM/WB cannot hold
  always_comb begin
    mem_wdata = ex_wdata;
    mem_wd    = ex_wd;
    mem_wreg  = ex_wreg;
    stall_req = 1'b0;
    misalign  = 1'b0;
    if (rst) begin
      mem_wdata = '0;
      mem_wd    = '0;
      mem_wreg  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mem) begin
            mem_wreg = 1'b0;
            if (w_aligned) stall_req = 1'b1;
            else           misalign  = 1'b1;
          end
        end
        S_WAIT: begin
          stall_req = 1'b1;
          mem_wreg  = 1'b0;
        end
        S_DONE: begin
          if (w_r_ld && !r_abort) mem_wdata = r_rdata;
          else                    mem_wreg  = 1'b0;
        end
        default: mem_wreg = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, misalignment,
// bus timeout and reset during a transaction.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [3:0]  ex_memop;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic [31:0] mem_wdata;
  logic [4:0]  mem_wd;
  logic        mem_wreg, stall_req, misalign, bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;
  int          stalls;

  mem_stage #(.DATA_W(32), .REG_AW(5), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_wdata(ex_wdata), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_memop(ex_memop),
    .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .stall_req(stall_req), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Starts at a negedge; returns #1 into the first non-stalled cycle (DONE).
  // ack_n = index of the WAIT cycle that gets dbus_ack (0 = never).
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sd, input int ack_n, input logic [31:0] rd);
    int ack_k;
    ack_k = 0;
    stalls = 0;
    ex_memop = op; ex_mem_addr = addr; ex_store_data = sd;
    for (int i = 0; i < 20; i++) begin
      if (dbus_req) begin
        ack_k++;
        if (ack_k == 1) begin
          cap_addr = dbus_addr; cap_be = dbus_be; cap_we = dbus_we; cap_wdata = dbus_wdata;
        end
        dbus_ack   = (ack_k == ack_n);
        dbus_rdata = rd;
      end else begin
        dbus_ack = 1'b0;
      end
      #1;
      if (stall_req) stalls++;
      else if (i > 0) break;
      @(negedge clk);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    ex_memop = 4'd0; dbus_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ex_wdata = 32'hDEAD_BEEF; ex_wd = 5'd9; ex_wreg = 1'b1; ex_memop = 4'd0;
    ex_mem_addr = 32'h0; ex_store_data = 32'h0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_req",   32'(dbus_req),  32'd0);
    check_val("rst_addr",  dbus_addr,      32'd0);
    check_val("rst_be",    32'(dbus_be),   32'd0);
    check_val("rst_berr",  32'(bus_err),   32'd0);
    check_val("rst_stall", 32'(stall_req), 32'd0);
    check_val("rst_wreg",  32'(mem_wreg),  32'd0);
    check_val("rst_wdata", mem_wdata,      32'd0);

    // pass-through
    @(negedge clk);
    rst = 1'b0;
    ex_memop = 4'd0; ex_wdata = 32'h1234_5678; ex_wd = 5'd3; ex_wreg = 1'b1;
    #1;
    check_val("pt_wdata", mem_wdata,      32'h1234_5678);
    check_val("pt_wd",    32'(mem_wd),    32'd3);
    check_val("pt_wreg",  32'(mem_wreg),  32'd1);
    check_val("pt_stall", 32'(stall_req), 32'd0);
    ex_memop = 4'd12;
    #1;
    check_val("pt_op12_wreg", 32'(mem_wreg), 32'd1);
    @(negedge clk);
    check_val("pt_req", 32'(dbus_req), 32'd0);

    // LB sign-extend, ack on 2nd WAIT cycle
    ex_wd = 5'd7; ex_wreg = 1'b1;
    run_op(4'd1, 32'h0000_1003, 32'h0, 2, 32'h80AA_BBCC);
    check_val("lb_addr",   cap_addr,       32'h0000_1000);
    check_val("lb_be",     32'(cap_be),    32'b1000);
    check_val("lb_we",     32'(cap_we),    32'd0);
    check_val("lb_stalls", 32'(stalls),    32'd3);
    check_val("lb_data",   mem_wdata,      32'hFFFF_FF80);
    check_val("lb_wreg",   32'(mem_wreg),  32'd1);
    check_val("lb_wd",     32'(mem_wd),    32'd7);
    check_val("lb_req",    32'(dbus_req),  32'd0);
    idle_cycle();

    // LHU upper half, ack on 1st WAIT cycle
    run_op(4'd4, 32'h0000_2002, 32'h0, 1, 32'hBEEF_1234);
    check_val("lhu_be",     32'(cap_be), 32'b1100);
    check_val("lhu_stalls", 32'(stalls), 32'd2);
    check_val("lhu_data",   mem_wdata,   32'h0000_BEEF);
    idle_cycle();

    run_op(4'd5, 32'h0000_2000, 32'h0, 1, 32'hBEEF_1234);
    check_val("lw_be",   32'(cap_be), 32'b1111);
    check_val("lw_data", mem_wdata,   32'hBEEF_1234);
    idle_cycle();

    run_op(4'd3, 32'h0000_2000, 32'h0, 3, 32'h1234_8765);
    check_val("lh_be",     32'(cap_be), 32'b0011);
    check_val("lh_stalls", 32'(stalls), 32'd4);
    check_val("lh_data",   mem_wdata,   32'hFFFF_8765);
    idle_cycle();

    run_op(4'd2, 32'h0000_2001, 32'h0, 1, 32'h0000_80FF);
    check_val("lbu_be",   32'(cap_be), 32'b0010);
    check_val("lbu_data", mem_wdata,   32'h0000_0080);
    idle_cycle();

    // stores
    run_op(4'd7, 32'h0000_3002, 32'h0000_CAFE, 1, 32'h0);
    check_val("sh_we",    32'(cap_we),   32'd1);
    check_val("sh_be",    32'(cap_be),   32'b1100);
    check_val("sh_wdata", cap_wdata,     32'hCAFE_CAFE);
    check_val("sh_addr",  cap_addr,      32'h0000_3000);
    check_val("sh_wreg",  32'(mem_wreg), 32'd0);
    idle_cycle();

    run_op(4'd6, 32'h0000_3001, 32'h1122_33A5, 2, 32'h0);
    check_val("sb_be",    32'(cap_be),   32'b0010);
    check_val("sb_wdata", cap_wdata,     32'hA5A5_A5A5);
    check_val("sb_wreg",  32'(mem_wreg), 32'd0);
    idle_cycle();

    run_op(4'd8, 32'h0000_3004, 32'h0BAD_F00D, 1, 32'h0);
    check_val("sw_be",    32'(cap_be), 32'b1111);
    check_val("sw_wdata", cap_wdata,   32'h0BAD_F00D);
    check_val("sw_addr",  cap_addr,    32'h0000_3004);
    idle_cycle();

    // misaligned LW and LH
    ex_memop = 4'd5; ex_mem_addr = 32'h0000_4001;
    #1;
    check_val("mis_lw_flag",  32'(misalign),  32'd1);
    check_val("mis_lw_stall", 32'(stall_req), 32'd0);
    check_val("mis_lw_wreg",  32'(mem_wreg),  32'd0);
    idle_cycle();
    #1;
    check_val("mis_lw_req",  32'(dbus_req), 32'd0);
    check_val("mis_lw_flag0", 32'(misalign), 32'd0);
    ex_memop = 4'd3; ex_mem_addr = 32'h0000_4003;
    #1;
    check_val("mis_lh_flag", 32'(misalign), 32'd1);
    idle_cycle();
    #1;
    check_val("mis_lh_req", 32'(dbus_req), 32'd0);

    // timeout: no ack within 4 WAIT cycles
    run_op(4'd5, 32'h0000_5000, 32'h0, 0, 32'h0);
    check_val("to_stalls", 32'(stalls),   32'd5);
    check_val("to_berr",   32'(bus_err),  32'd1);
    check_val("to_wreg",   32'(mem_wreg), 32'd0);
    check_val("to_req",    32'(dbus_req), 32'd0);
    idle_cycle();
    #1;
    check_val("to_berr_clr", 32'(bus_err), 32'd0);

    // ack on the limit cycle still succeeds
    run_op(4'd5, 32'h0000_5000, 32'h0, 4, 32'h5555_AAAA);
    check_val("lim_stalls", 32'(stalls),   32'd5);
    check_val("lim_berr",   32'(bus_err),  32'd0);
    check_val("lim_wreg",   32'(mem_wreg), 32'd1);
    check_val("lim_data",   mem_wdata,     32'h5555_AAAA);
    idle_cycle();

    // reset in the middle of WAIT
    ex_memop = 4'd5; ex_mem_addr = 32'h0000_6000;
    @(negedge clk);
    check_val("mr_req_on", 32'(dbus_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_val("mr_req",   32'(dbus_req),  32'd0);
    check_val("mr_addr",  dbus_addr,      32'd0);
    check_val("mr_stall", 32'(stall_req), 32'd0);
    check_val("mr_wreg",  32'(mem_wreg),  32'd0);
    rst = 1'b0; ex_memop = 4'd0; ex_wdata = 32'h0000_00AB;
    #1;
    check_val("mr_idle_stall", 32'(stall_req), 32'd0);
    check_val("mr_idle_wdata", mem_wdata,      32'h0000_00AB);
    @(negedge clk);
    check_val("mr_idle_req", 32'(dbus_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
